sap_control_sequencer: RTL and testbench
========================================

Name: sap_control_sequencer

Overview:
Controller-sequencer for the SAP-1 core; sits directly downstream of the instruction decoder. It consumes the decoded one-hot instruction strobes (lda, add, sub, out, active-low hlt) and runs the fetch/execute ring counter T1..T6. From that state it drives the 12-bit control word for the PC, MAR, RAM, IR, accumulator, B register, ALU and output register. It also owns the halt latch that freezes the machine.

Parameters:
VARIABLE_CYCLE, 0, 0: every instruction takes T1..T6. 1: skip trailing NOP states; LDA returns to T1 after T5, OUT after T4, an unknown opcode after T3.

Ports:
clk  in  1  system clock; sequencer state updates on the falling edge.
clr_n  in  1  asynchronous active-low reset.
lda  in  1  decoded LDA, active high.
add  in  1  decoded ADD, active high.
sub  in  1  decoded SUB, active high.
out  in  1  decoded OUT, active high.
hlt  in  1  decoded HLT, active low.
cp  out  1  PC increment, active high.
ep  out  1  PC drives bus, active high.
lm_n  out  1  MAR load, active low.
ce_n  out  1  RAM drives bus, active low.
li_n  out  1  IR load, active low.
ei_n  out  1  IR operand drives bus, active low.
la_n  out  1  accumulator load, active low.
ea  out  1  accumulator drives bus, active high.
su  out  1  ALU subtract select, active high.
eu  out  1  ALU drives bus, active high.
lb_n  out  1  B register load, active low.
lo_n  out  1  output register load, active low.
t_state  out  6  one-hot ring state; bit0 = T1.
halted  out  1  high once HLT is executed; the PC clock gate uses it.

Behaviour:
- Reset (clr_n low, asynchronous): t_state=6'b000001, halted=0, all control outputs inactive (cp, ep, ea, su, eu = 0; every *_n = 1). The control word for T1 appears only after clr_n deasserts.
- State register advances on the negedge of clk. Control outputs are combinational from t_state, halted and the decoder inputs, so they are stable at the next posedge, where datapath registers load.
- Ring: T1→T2→…→T6→T1. With VARIABLE_CYCLE=1, the early return happens from the last active T-state.
- Control word per state (signals not listed are inactive):
  - T1: ep, lm_n.
  - T2: cp.
  - T3: ce_n, li_n.
  - T4: LDA/ADD/SUB: ei_n, lm_n. OUT: ea, lo_n.
  - T5: LDA: ce_n, la_n. ADD/SUB: ce_n, lb_n.
  - T6: ADD: eu, la_n. SUB: su, eu, la_n.
  - All other combinations are NOP.
- Decoder inputs are meaningful only in T4..T6. They are ignored in T1..T3 while the IR is loading.
- Priority when several strobes are asserted at once (illegal, but defined): hlt low > lda > add > sub > out.
- Halt:
  - In T4, hlt=0 forces an all-inactive control word.
  - At the next negedge, halted is set and t_state holds 6'b001000 (T4).
  - While halted, t_state is frozen, the control word stays all-inactive and cp never pulses.
  - Only clr_n clears halted.
- Unknown opcode (no strobe, hlt=1) in T4: NOP for T4..T6, or return to T1 after T3 when VARIABLE_CYCLE=1.
- Reset asserted mid-instruction: immediate return to the reset values; no partial control word is emitted after clr_n falls.
- t_state is always exactly one-hot. An illegal encoding, unreachable in normal operation, recovers to T1 on the next negedge.

Decomposition:
- Shared package sap_pkg holds:
  - T-state one-hot constants T1..T6.
  - The control-word bit indices.
  - CW_INACTIVE: the 12-bit all-inactive control word.
  - The opcode constants used by the decoder: LDA 0000, ADD 0001, SUB 0010, OUT 1110, HLT 1111.
- One natural sub-module: sap_ring_counter, the 6-bit one-hot ring with async clear, freeze and early-return inputs.
- Control-word generation stays in the top module.

Test Plan:
- Reset, then 3 negedges with lda=1 → t_state 000001→000010→000100→001000. Control words: T1 {ep=1, lm_n=0}, T2 {cp=1}, T3 {ce_n=0, li_n=0}.
- ADD for one full cycle → T4 {ei_n=0, lm_n=0}, T5 {ce_n=0, lb_n=0}, T6 {eu=1, la_n=0, su=0}, then back to T1. Repeat with sub=1 → T6 has su=1.
- OUT with VARIABLE_CYCLE=0 → T4 {ea=1, lo_n=0}, T5/T6 all-inactive, 6 clocks per instruction. With VARIABLE_CYCLE=1 → t_state returns to 000001 after T4 (4 clocks).
- hlt=0 in T4 → all-inactive control word. halted=1 after that negedge; t_state stays 001000 for 20 further clocks with cp=0 throughout. Pulse clr_n low → halted=0, t_state=000001.
- hlt=0 pulsed during T2 → ignored: sequence continues to T3, halted stays 0.
- clr_n asserted asynchronously mid-T5 of LDA (between clock edges) → outputs go to CW_INACTIVE and t_state=000001 immediately. After release, fetch restarts at T1.

Source files
------------

// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP-1 controller-sequencer slice:
//   - one-hot T-state constants T1..T6 (bit0 = T1)
//   - bit positions of the 12-bit control word
//   - CW_INACTIVE, the control word with every signal deasserted
//   - the 4-bit opcodes recognised by the instruction decoder
//   - ins_e, the instruction class the sequencer resolves from the strobes
// ---------------------------------------------------------------------------
package sap_pkg;

   localparam logic [5:0] T1 = 6'b000001;
   localparam logic [5:0] T2 = 6'b000010;
   localparam logic [5:0] T3 = 6'b000100;
   localparam logic [5:0] T4 = 6'b001000;
   localparam logic [5:0] T5 = 6'b010000;
   localparam logic [5:0] T6 = 6'b100000;

   // Control word layout, MSB first: cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n
   localparam int CW_CP   = 11;
   localparam int CW_EP   = 10;
   localparam int CW_LM_N = 9;
   localparam int CW_CE_N = 8;
   localparam int CW_LI_N = 7;
   localparam int CW_EI_N = 6;
   localparam int CW_LA_N = 5;
   localparam int CW_EA   = 4;
   localparam int CW_SU   = 3;
   localparam int CW_EU   = 2;
   localparam int CW_LB_N = 1;
   localparam int CW_LO_N = 0;

   // Active-low strobes sit at 1, active-high strobes at 0
   localparam logic [11:0] CW_INACTIVE = 12'h3E3;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   typedef enum logic [2:0] {
      INS_NONE,
      INS_LDA,
      INS_ADD,
      INS_SUB,
      INS_OUT,
      INS_HLT
   } ins_e;

   // True when exactly one bit of the ring is set
   function automatic logic is_onehot6(input logic [5:0] v);
      return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
   endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// ---------------------------------------------------------------------------
// sap_ring_counter
// Six-state one-hot fetch/execute ring T1..T6, advancing on the falling clock
// edge so that the decoded control word is settled by the next rising edge.
// Ports:
//   clk          in   system clock (state moves on negedge)
//   clr_n        in   asynchronous active-low clear, forces T1
//   freeze       in   hold the current state (halt)
//   early_return in   jump back to T1 instead of advancing
//   t_state      out  one-hot state, bit0 = T1
// ---------------------------------------------------------------------------
module sap_ring_counter
   import sap_pkg::*;
(
   input  logic       clk,
   input  logic       clr_n,
   input  logic       freeze,
   input  logic       early_return,
   output logic [5:0] t_state
);

   // Ring register. A corrupted (non one-hot) value is pulled back to T1
   // ahead of everything else so the sequencer can never lock up; freeze
   // outranks early_return so a halted machine stays put.
   always_ff @(negedge clk or negedge clr_n) begin
      if (!clr_n) begin
         t_state <= T1;
      end else if (!is_onehot6(t_state)) begin
         t_state <= T1;
      end else if (freeze) begin
         t_state <= t_state;
      end else if (early_return) begin
         t_state <= T1;
      end else begin
         t_state <= {t_state[4:0], t_state[5]};
      end
   end

endmodule

// File: rtl/sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// sap_control_sequencer
// SAP-1 controller-sequencer: runs the T1..T6 ring, owns the halt latch and
// decodes the ring state plus instruction strobes into the control word.
// Ports:
//   clk, clr_n               clock (negedge state update), async active-low reset
//   lda, add, sub, out       decoded instruction strobes, active high
//   hlt                      decoded HLT, active low
//   cp, ep, ea, su, eu       active-high control outputs
//   lm_n, ce_n, li_n, ei_n,
//   la_n, lb_n, lo_n         active-low control outputs
//   t_state                  one-hot ring state, bit0 = T1
//   halted                   set once HLT executes, cleared only by clr_n
// ---------------------------------------------------------------------------
module sap_control_sequencer
   import sap_pkg::*;
#(
   parameter bit VARIABLE_CYCLE = 1'b0
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       lda,
   input  logic       add,
   input  logic       sub,
   input  logic       out,
   input  logic       hlt,
   output logic       cp,
   output logic       ep,
   output logic       lm_n,
   output logic       ce_n,
   output logic       li_n,
   output logic       ei_n,
   output logic       la_n,
   output logic       ea,
   output logic       su,
   output logic       eu,
   output logic       lb_n,
   output logic       lo_n,
   output logic [5:0] t_state,
   output logic       halted
);

   ins_e        ins;
   logic        halt_req;
   logic        early_return;
   logic [11:0] cw;

   // Resolve the strobes into one instruction class. Several strobes at once
   // is illegal but still deterministic: hlt low wins, then lda, add, sub, out.
   always_comb begin
      ins = INS_NONE;
      if (!hlt) begin
         ins = INS_HLT;
      end else if (lda) begin
         ins = INS_LDA;
      end else if (add) begin
         ins = INS_ADD;
      end else if (sub) begin
         ins = INS_SUB;
      end else if (out) begin
         ins = INS_OUT;
      end
   end

   assign halt_req = (t_state == T4) && (ins == INS_HLT);

   // The IR has loaded by the rising edge inside T3, so the class is already
   // valid at the falling edge that ends T3 and an unknown opcode can skip
   // straight back to fetch from there.
   assign early_return = VARIABLE_CYCLE &&
                         (((t_state == T3) && (ins == INS_NONE)) ||
                          ((t_state == T4) && (ins == INS_OUT))  ||
                          ((t_state == T5) && (ins == INS_LDA)));

   sap_ring_counter u_ring (
      .clk          (clk),
      .clr_n        (clr_n),
      .freeze       (halted || halt_req),
      .early_return (early_return),
      .t_state      (t_state)
   );

   // Halt latch: set on the falling edge that ends a T4 carrying HLT, and
   // from then on only clr_n can release it.
   always_ff @(negedge clk or negedge clr_n) begin
      if (!clr_n) begin
         halted <= 1'b0;
      end else if (halt_req) begin
         halted <= 1'b1;
      end
   end

   // Control word from ring state and instruction class. clr_n gates it
   // directly so nothing leaks out while reset is held (the ring already
   // reads T1 then), and a halted machine emits nothing at all.
   always_comb begin
      cw = CW_INACTIVE;
      if (clr_n && !halted) begin
         case (t_state)
            T1: begin
               cw[CW_EP]   = 1'b1;
               cw[CW_LM_N] = 1'b0;
            end
            T2: begin
               cw[CW_CP] = 1'b1;
            end
            T3: begin
               cw[CW_CE_N] = 1'b0;
               cw[CW_LI_N] = 1'b0;
            end
            T4: begin
               if ((ins == INS_LDA) || (ins == INS_ADD) || (ins == INS_SUB)) begin
                  cw[CW_EI_N] = 1'b0;
                  cw[CW_LM_N] = 1'b0;
               end else if (ins == INS_OUT) begin
                  cw[CW_EA]   = 1'b1;
                  cw[CW_LO_N] = 1'b0;
               end
            end
            T5: begin
               if (ins == INS_LDA) begin
                  cw[CW_CE_N] = 1'b0;
                  cw[CW_LA_N] = 1'b0;
               end else if ((ins == INS_ADD) || (ins == INS_SUB)) begin
                  cw[CW_CE_N] = 1'b0;
                  cw[CW_LB_N] = 1'b0;
               end
            end
            T6: begin
               if ((ins == INS_ADD) || (ins == INS_SUB)) begin
                  cw[CW_EU]   = 1'b1;
                  cw[CW_LA_N] = 1'b0;
                  cw[CW_SU]   = (ins == INS_SUB);
               end
            end
            default: begin
               cw = CW_INACTIVE;
            end
         endcase
      end
   end

   assign cp   = cw[CW_CP];
   assign ep   = cw[CW_EP];
   assign lm_n = cw[CW_LM_N];
   assign ce_n = cw[CW_CE_N];
   assign li_n = cw[CW_LI_N];
   assign ei_n = cw[CW_EI_N];
   assign la_n = cw[CW_LA_N];
   assign ea   = cw[CW_EA];
   assign su   = cw[CW_SU];
   assign eu   = cw[CW_EU];
   assign lb_n = cw[CW_LB_N];
   assign lo_n = cw[CW_LO_N];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sap_control_sequencer
// Two sequencers side by side on shared inputs: dut0 fixed six-state cycle,
// dut1 with early return. A directed vector table walks dut0 through every
// instruction; a reference model of both machines follows all activity,
// including hand-built halt / async-reset sequences and a random run.
// ---------------------------------------------------------------------------
module tb_sap_control_sequencer;

   // Control word packing used here: cp ep lm_n ce_n li_n ei_n la_n ea su eu lb_n lo_n
   localparam logic [11:0] INACT = 12'h3E3;
   localparam logic [11:0] B_CP = 12'h800;
   localparam logic [11:0] B_EP = 12'h400;
   localparam logic [11:0] B_LM = 12'h200;
   localparam logic [11:0] B_CE = 12'h100;
   localparam logic [11:0] B_LI = 12'h080;
   localparam logic [11:0] B_EI = 12'h040;
   localparam logic [11:0] B_LA = 12'h020;
   localparam logic [11:0] B_EA = 12'h010;
   localparam logic [11:0] B_SU = 12'h008;
   localparam logic [11:0] B_EU = 12'h004;
   localparam logic [11:0] B_LB = 12'h002;
   localparam logic [11:0] B_LO = 12'h001;

   // Input patterns {lda, add, sub, out, hlt}
   localparam logic [4:0] I_LDA  = 5'b10001;
   localparam logic [4:0] I_ADD  = 5'b01001;
   localparam logic [4:0] I_SUB  = 5'b00101;
   localparam logic [4:0] I_OUT  = 5'b00011;
   localparam logic [4:0] I_NONE = 5'b00001;
   localparam logic [4:0] I_HLT  = 5'b00000;
   localparam logic [4:0] I_ALL  = 5'b11111;

   localparam int M_NONE = 0;
   localparam int M_LDA  = 1;
   localparam int M_ADD  = 2;
   localparam int M_SUB  = 3;
   localparam int M_OUT  = 4;
   localparam int M_HLT  = 5;

   typedef struct {
      logic [4:0]  ins;
      logic [5:0]  t;
      logic [11:0] cw;
   } vec_t;

   logic clk;
   logic clr_n;
   logic lda, add, sub, out, hlt;

   logic [1:0] cp_d, ep_d, lm_n_d, ce_n_d, li_n_d, ei_n_d, la_n_d;
   logic [1:0] ea_d, su_d, eu_d, lb_n_d, lo_n_d, halted_d;
   logic [5:0] t_d [2];

   int compared;
   int mismatched;
   int m_t [2];
   bit m_h [2];
   vec_t tbl [$];

   sap_control_sequencer #(.VARIABLE_CYCLE(1'b0)) dut0 (
      .clk(clk), .clr_n(clr_n),
      .lda(lda), .add(add), .sub(sub), .out(out), .hlt(hlt),
      .cp(cp_d[0]), .ep(ep_d[0]), .lm_n(lm_n_d[0]), .ce_n(ce_n_d[0]),
      .li_n(li_n_d[0]), .ei_n(ei_n_d[0]), .la_n(la_n_d[0]), .ea(ea_d[0]),
      .su(su_d[0]), .eu(eu_d[0]), .lb_n(lb_n_d[0]), .lo_n(lo_n_d[0]),
      .t_state(t_d[0]), .halted(halted_d[0])
   );

   sap_control_sequencer #(.VARIABLE_CYCLE(1'b1)) dut1 (
      .clk(clk), .clr_n(clr_n),
      .lda(lda), .add(add), .sub(sub), .out(out), .hlt(hlt),
      .cp(cp_d[1]), .ep(ep_d[1]), .lm_n(lm_n_d[1]), .ce_n(ce_n_d[1]),
      .li_n(li_n_d[1]), .ei_n(ei_n_d[1]), .la_n(la_n_d[1]), .ea(ea_d[1]),
      .su(su_d[1]), .eu(eu_d[1]), .lb_n(lb_n_d[1]), .lo_n(lo_n_d[1]),
      .t_state(t_d[1]), .halted(halted_d[1])
   );

   // Free-running clock; the sequencers step on the falling edge
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the run ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not reach its end");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [11:0] dutCw(input int d);
      return {cp_d[d], ep_d[d], lm_n_d[d], ce_n_d[d], li_n_d[d], ei_n_d[d],
              la_n_d[d], ea_d[d], su_d[d], eu_d[d], lb_n_d[d], lo_n_d[d]};
   endfunction

   function automatic logic [4:0] curIns();
      return {lda, add, sub, out, hlt};
   endfunction

   function automatic int decodeOp(input logic [4:0] v);
      if (!v[0]) return M_HLT;
      if (v[4])  return M_LDA;
      if (v[3])  return M_ADD;
      if (v[2])  return M_SUB;
      if (v[1])  return M_OUT;
      return M_NONE;
   endfunction

   // Last T-state doing real work for each instruction
   function automatic int lastState(input int op);
      case (op)
         M_LDA:   return 5;
         M_OUT:   return 4;
         M_NONE:  return 3;
         default: return 6;
      endcase
   endfunction

   // What the datapath must see in step tn for the given instruction
   function automatic logic [11:0] modelCw(input int tn, input bit hal,
                                           input logic rst_n, input logic [4:0] v);
      int op;
      op = decodeOp(v);
      if (!rst_n || hal) return INACT;
      case (tn)
         1: return INACT ^ (B_EP | B_LM);
         2: return INACT ^ B_CP;
         3: return INACT ^ (B_CE | B_LI);
         4: begin
            if (op == M_LDA || op == M_ADD || op == M_SUB) return INACT ^ (B_EI | B_LM);
            if (op == M_OUT) return INACT ^ (B_EA | B_LO);
            return INACT;
         end
         5: begin
            if (op == M_LDA) return INACT ^ (B_CE | B_LA);
            if (op == M_ADD || op == M_SUB) return INACT ^ (B_CE | B_LB);
            return INACT;
         end
         6: begin
            if (op == M_ADD) return INACT ^ (B_EU | B_LA);
            if (op == M_SUB) return INACT ^ (B_SU | B_EU | B_LA);
            return INACT;
         end
         default: return INACT;
      endcase
   endfunction

   function automatic vec_t mkvec(input logic [4:0] i, input int tn, input logic [11:0] act);
      vec_t v;
      v.ins = i;
      v.t   = 6'(1 << (tn - 1));
      v.cw  = INACT ^ act;
      return v;
   endfunction

   task automatic cmp(input string name, input int d, input logic [11:0] got,
                      input logic [11:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s dut%0d at %0t: got %b, expected %b", name, d, $time, got, exp);
      end
   endtask

   task automatic checkOutput(input int d);
      cmp("t_state", d, 12'(t_d[d]), 12'(1 << (m_t[d] - 1)));
      cmp("halted", d, 12'(halted_d[d]), 12'(m_h[d]));
      cmp("cw", d, dutCw(d), modelCw(m_t[d], m_h[d], clr_n, curIns()));
   endtask

   task automatic applyStimulus(input logic [4:0] v);
      {lda, add, sub, out, hlt} = v;
   endtask

   task automatic modelAdvance();
      int op;
      op = decodeOp(curIns());
      for (int d = 0; d < 2; d++) begin
         if (!clr_n) begin
            m_t[d] = 1;
            m_h[d] = 1'b0;
         end else if (m_h[d]) begin
            m_t[d] = m_t[d];
         end else if (m_t[d] == 4 && op == M_HLT) begin
            m_h[d] = 1'b1;
         end else if (d == 1 && m_t[d] == lastState(op)) begin
            m_t[d] = 1;
         end else begin
            m_t[d] = (m_t[d] % 6) + 1;
         end
      end
   endtask

   task automatic sampleEdge();
      @(posedge clk);
      #1;
   endtask

   task automatic advanceEdge();
      @(negedge clk);
      modelAdvance();
      #1;
   endtask

   task automatic step();
      sampleEdge();
      checkOutput(0);
      checkOutput(1);
      advanceEdge();
   endtask

   // Asserts clr_n wherever the bench currently is, checks the immediate
   // response, then releases just after a falling edge.
   task automatic applyReset();
      clr_n = 1'b0;
      m_t[0] = 1; m_t[1] = 1;
      m_h[0] = 1'b0; m_h[1] = 1'b0;
      #1;
      checkOutput(0);
      checkOutput(1);
      @(negedge clk);
      #1;
      clr_n = 1'b1;
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      clr_n = 1'b1;
      applyStimulus(I_NONE);

      // Directed table for the fixed-length sequencer
      tbl.push_back(mkvec(I_LDA, 1, B_EP | B_LM));
      tbl.push_back(mkvec(I_LDA, 2, B_CP));
      tbl.push_back(mkvec(I_LDA, 3, B_CE | B_LI));
      tbl.push_back(mkvec(I_LDA, 4, B_EI | B_LM));
      tbl.push_back(mkvec(I_LDA, 5, B_CE | B_LA));
      tbl.push_back(mkvec(I_LDA, 6, 12'h000));
      tbl.push_back(mkvec(I_ADD, 1, B_EP | B_LM));
      tbl.push_back(mkvec(I_ADD, 2, B_CP));
      tbl.push_back(mkvec(I_ADD, 3, B_CE | B_LI));
      tbl.push_back(mkvec(I_ADD, 4, B_EI | B_LM));
      tbl.push_back(mkvec(I_ADD, 5, B_CE | B_LB));
      tbl.push_back(mkvec(I_ADD, 6, B_EU | B_LA));
      tbl.push_back(mkvec(I_OUT, 1, B_EP | B_LM));
      tbl.push_back(mkvec(I_HLT, 2, B_CP));
      tbl.push_back(mkvec(I_SUB, 3, B_CE | B_LI));
      tbl.push_back(mkvec(I_SUB, 4, B_EI | B_LM));
      tbl.push_back(mkvec(I_SUB, 5, B_CE | B_LB));
      tbl.push_back(mkvec(I_SUB, 6, B_SU | B_EU | B_LA));
      tbl.push_back(mkvec(I_OUT, 1, B_EP | B_LM));
      tbl.push_back(mkvec(I_OUT, 2, B_CP));
      tbl.push_back(mkvec(I_OUT, 3, B_CE | B_LI));
      tbl.push_back(mkvec(I_OUT, 4, B_EA | B_LO));
      tbl.push_back(mkvec(I_OUT, 5, 12'h000));
      tbl.push_back(mkvec(I_OUT, 6, 12'h000));
      tbl.push_back(mkvec(I_NONE, 1, B_EP | B_LM));
      tbl.push_back(mkvec(I_NONE, 2, B_CP));
      tbl.push_back(mkvec(I_NONE, 3, B_CE | B_LI));
      tbl.push_back(mkvec(I_NONE, 4, 12'h000));
      tbl.push_back(mkvec(I_NONE, 5, 12'h000));
      tbl.push_back(mkvec(I_NONE, 6, 12'h000));
      tbl.push_back(mkvec(I_ALL, 1, B_EP | B_LM));
      tbl.push_back(mkvec(I_ALL, 2, B_CP));
      tbl.push_back(mkvec(I_ALL, 3, B_CE | B_LI));
      tbl.push_back(mkvec(I_ALL, 4, B_EI | B_LM));
      tbl.push_back(mkvec(I_ALL, 5, B_CE | B_LA));
      tbl.push_back(mkvec(I_ALL, 6, 12'h000));
      tbl.push_back(mkvec(I_LDA, 1, B_EP | B_LM));

      #2;
      applyReset();

      foreach (tbl[k]) begin
         applyStimulus(tbl[k].ins);
         sampleEdge();
         cmp($sformatf("tbl%0d_t", k), 0, 12'(t_d[0]), 12'(tbl[k].t));
         cmp($sformatf("tbl%0d_cw", k), 0, dutCw(0), tbl[k].cw);
         cmp($sformatf("tbl%0d_halted", k), 0, 12'(halted_d[0]), 12'h000);
         checkOutput(1);
         advanceEdge();
      end

      // OUT on the early-return sequencer wraps after four states
      applyReset();
      applyStimulus(I_OUT);
      for (int i = 0; i < 4; i++) step();
      sampleEdge();
      cmp("out_vc1_wrap", 1, 12'(t_d[1]), 12'h001);
      cmp("out_vc0_t5", 0, 12'(t_d[0]), 12'h010);
      advanceEdge();

      // HLT: freeze in T4 with nothing driven, then async clear
      applyReset();
      applyStimulus(I_HLT);
      for (int i = 0; i < 4; i++) step();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(5'($urandom));
         sampleEdge();
         cmp("halt_cp", 0, 12'(cp_d[0]), 12'h000);
         checkOutput(0);
         checkOutput(1);
         advanceEdge();
      end
      cmp("halt_t_hold", 0, 12'(t_d[0]), 12'h008);
      cmp("halt_flag", 1, 12'(halted_d[1]), 12'h001);
      sampleEdge();
      applyReset();
      applyStimulus(I_LDA);
      step();

      // Async clear in the middle of LDA T5
      applyReset();
      applyStimulus(I_LDA);
      for (int i = 0; i < 4; i++) step();
      sampleEdge();
      checkOutput(0);
      checkOutput(1);
      #2;
      applyReset();
      step();
      step();

      // Randomised run against the model
      for (int i = 0; i < 400; i++) begin
         logic [3:0] s;
         logic       h;
         if ((m_h[0] && m_h[1]) || $urandom_range(0, 59) == 0) begin
            applyReset();
         end
         h = ($urandom_range(0, 99) < 4) ? 1'b0 : 1'b1;
         case ($urandom_range(0, 9))
            0, 1:    s = 4'b0000;
            2, 3:    s = 4'b1000;
            4, 5:    s = 4'b0100;
            6, 7:    s = 4'b0010;
            8:       s = 4'b0001;
            default: s = 4'($urandom);
         endcase
         applyStimulus({s, h});
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
